// File: rtl/pea_pkg.sv
// Shared PEA parameters plus the configuration-loader FSM state type.
// The step index is one bit wider than the slot index so that out-of-range last-step requests can be clamped.
package pea_pkg;
    localparam int N               = 2;
    localparam int M               = 2;
    localparam int KMEM_SIZE       = 4;
    localparam int N_CFG_BITS_PE   = 32;
    localparam int N_CFG_ADDR_BITS = 3;

    localparam int N_ROW_BITS      = (N > 1) ? $clog2(N) : 1;
    localparam int N_COL_BITS      = (M > 1) ? $clog2(M) : 1;
    localparam int N_KMEM_IDX_BITS = (KMEM_SIZE > 1) ? $clog2(KMEM_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } cfg_ldr_state_t;

    // Requests beyond the physical slot count are clamped to the last slot.
    function automatic logic [N_CFG_ADDR_BITS-1:0] clamp_step(input logic [N_CFG_ADDR_BITS-1:0] s);
        if (s > N_CFG_ADDR_BITS'(KMEM_SIZE - 1))
            return N_CFG_ADDR_BITS'(KMEM_SIZE - 1);
        return s;
    endfunction
endpackage

// File: rtl/cfg_idx_cnt.sv
// Nested col/step/row counter that walks the config stream order.
// Column is the fastest index and row is the slowest.
module cfg_idx_cnt
    import pea_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic                       clr,
    input  logic [N_CFG_ADDR_BITS-1:0] last_step,
    output logic [N_ROW_BITS-1:0]      row,
    output logic [N_COL_BITS-1:0]      col,
    output logic [N_CFG_ADDR_BITS-1:0] step,
    output logic                       last_beat
);
    logic col_wrap;
    logic step_wrap;

    assign col_wrap  = (col == N_COL_BITS'(M - 1));
    assign step_wrap = (step == last_step);
    assign last_beat = col_wrap && step_wrap && (row == N_ROW_BITS'(N - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            row  <= '0;
            col  <= '0;
            step <= '0;
        end else if (en) begin
            if (col_wrap) begin
                col <= '0;
                if (step_wrap) begin
                    step <= '0;
                    row  <= row + N_ROW_BITS'(1);
                end else begin
                    step <= step + N_CFG_ADDR_BITS'(1);
                end
            end else begin
                col <= col + N_COL_BITS'(1);
            end
        end
    end
endmodule

// File: rtl/cfg_loader_pea.sv
// Streams PE configuration words into the per-PE, per-slot config storage.
// The storage is exposed as a flat array that feeds the PEA configuration-read path.
module cfg_loader_pea
    import pea_pkg::*;
(
    input  logic                       clk_i,
    input  logic                       rst_n_i,
    input  logic                       start_i,
    input  logic [N_CFG_ADDR_BITS-1:0] last_step_i,
    input  logic                       abort_i,
    input  logic                       cfg_valid_i,
    input  logic [N_CFG_BITS_PE-1:0]   cfg_data_i,
    output logic                       cfg_ready_o,
    output logic [N-1:0][M-1:0][KMEM_SIZE-1:0][N_CFG_BITS_PE-1:0] reg_cfg_pea_o,
    output logic                       busy_o,
    output logic                       done_o
);
    cfg_ldr_state_t             state, state_nxt;
    logic [N_CFG_ADDR_BITS-1:0] last_step_q;
    logic [N_ROW_BITS-1:0]      row;
    logic [N_COL_BITS-1:0]      col;
    logic [N_CFG_ADDR_BITS-1:0] step;
    logic                       last_beat;
    logic                       hs;

    assign hs = cfg_valid_i && cfg_ready_o;

    cfg_idx_cnt u_idx (
        .clk       (clk_i),
        .rst_n     (rst_n_i),
        .en        (hs),
        .clr       (state == IDLE),
        .last_step (last_step_q),
        .row       (row),
        .col       (col),
        .step      (step),
        .last_beat (last_beat)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            last_step_q <= '0;
        else if (state == IDLE && start_i)
            last_step_q <= clamp_step(last_step_i);
    end

    // Abort wins over the final beat: the word is still written but no done pulse.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = LOAD;
            LOAD: begin
                if (abort_i)              state_nxt = IDLE;
                else if (hs && last_beat) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decode the state register only, so they change exactly at clock edges.
    always_comb begin
        cfg_ready_o = (state == LOAD);
        busy_o      = (state != IDLE);
        done_o      = (state == DONE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i)
            reg_cfg_pea_o <= '0;
        else if (hs)
            reg_cfg_pea_o[row][col][step[N_KMEM_IDX_BITS-1:0]] <= cfg_data_i;
    end
endmodule

// File: tb/tb_cfg_loader_pea.sv
// Directed bench for cfg_loader_pea.
// Covers full, partial, clamped, back-pressured, aborted and reset-interrupted loads.
module tb_cfg_loader_pea;
    import pea_pkg::*;

    logic                       clk_i = 1'b0;
    logic                       rst_n_i;
    logic                       start_i;
    logic [N_CFG_ADDR_BITS-1:0] last_step_i;
    logic                       abort_i;
    logic                       cfg_valid_i;
    logic [N_CFG_BITS_PE-1:0]   cfg_data_i;
    logic                       cfg_ready_o;
    logic [N-1:0][M-1:0][KMEM_SIZE-1:0][N_CFG_BITS_PE-1:0] reg_cfg_pea_o;
    logic                       busy_o;
    logic                       done_o;

    int checks   = 0;
    int failures = 0;

    cfg_loader_pea dut (
        .clk_i         (clk_i),
        .rst_n_i       (rst_n_i),
        .start_i       (start_i),
        .last_step_i   (last_step_i),
        .abort_i       (abort_i),
        .cfg_valid_i   (cfg_valid_i),
        .cfg_data_i    (cfg_data_i),
        .cfg_ready_o   (cfg_ready_o),
        .reg_cfg_pea_o (reg_cfg_pea_o),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // kind 0: base + linear beat index; 1: partial load over 0xFFFFFFFF;
    // kind 2: abort after 5 beats over the 0x100 pattern; other: zeros.
    function automatic logic [31:0] exp_val(input int kind, input int base, input int r, input int s, input int c);
        int k;
        k = r*8 + s*2 + c;
        case (kind)
            0:       return 32'(base + k);
            1:       return (s < 2) ? 32'(32'hA0 + r*4 + s*2 + c) : 32'hFFFF_FFFF;
            2:       return (k < 5) ? 32'(32'h300 + k) : 32'(32'h100 + k);
            default: return 32'h0;
        endcase
    endfunction

    task automatic chk_arr(input string tag, input int kind, input int base);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < M; c++)
                for (int s = 0; s < KMEM_SIZE; s++)
                    chk($sformatf("%s[%0d][%0d][%0d]", tag, r, c, s),
                        reg_cfg_pea_o[r][c][s], exp_val(kind, base, r, s, c));
    endtask

    task automatic do_start(input string tag, input logic [N_CFG_ADDR_BITS-1:0] ls);
        start_i     = 1'b1;
        last_step_i = ls;
        tick();
        start_i     = 1'b0;
        chk({tag, "_ready_on_start"}, 32'(cfg_ready_o), 32'd1);
        chk({tag, "_busy_on_start"},  32'(busy_o),      32'd1);
    endtask

    // Streams words until nbeats handshakes occur or the cycle budget expires.
    task automatic stream(input string tag, input int nbeats, input logic [31:0] base,
                          input int inc, input bit gaps);
        int acc;
        int cyc;
        acc = 0;
        cyc = 0;
        while (acc < nbeats && cyc < 400) begin
            cfg_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            cfg_data_i  = base + 32'(acc * inc);
            if (acc > 0) chk({tag, "_no_early_done"}, 32'(done_o), 32'd0);
            if (cfg_valid_i && cfg_ready_o) acc++;
            tick();
            cyc++;
        end
        cfg_valid_i = 1'b0;
        chk({tag, "_beats"}, 32'(acc), 32'(nbeats));
    endtask

    task automatic chk_finish(input string tag);
        chk({tag, "_done_pulse"},    32'(done_o),      32'd1);
        chk({tag, "_ready_in_done"}, 32'(cfg_ready_o), 32'd0);
        tick();
        chk({tag, "_done_cleared"},  32'(done_o),      32'd0);
        chk({tag, "_idle_busy"},     32'(busy_o),      32'd0);
    endtask

    initial begin
        rst_n_i     = 1'b0;
        start_i     = 1'b0;
        last_step_i = '0;
        abort_i     = 1'b0;
        cfg_valid_i = 1'b0;
        cfg_data_i  = '0;
        tick();
        tick();
        chk("rst_ready", 32'(cfg_ready_o), 32'd0);
        chk("rst_busy",  32'(busy_o),      32'd0);
        chk("rst_done",  32'(done_o),      32'd0);
        chk_arr("rst_arr", 3, 0);
        rst_n_i = 1'b1;

        // valid while idle must not write or be accepted
        cfg_valid_i = 1'b1;
        cfg_data_i  = 32'hDEAD_BEEF;
        tick();
        chk("idle_ready", 32'(cfg_ready_o), 32'd0);
        chk("idle_nowrite", reg_cfg_pea_o[0][0][0], 32'h0);
        cfg_valid_i = 1'b0;

        // full load, back-to-back
        do_start("full", 3'd3);
        stream("full", 16, 32'h100, 1, 1'b0);
        chk_finish("full");
        chk_arr("full_arr", 0, 32'h100);

        // partial load over a preloaded array
        do_start("pre", 3'd3);
        stream("pre", 16, 32'hFFFF_FFFF, 0, 1'b0);
        chk_finish("pre");
        do_start("part", 3'd1);
        stream("part", 8, 32'hA0, 1, 1'b0);
        chk_finish("part");
        chk_arr("part_arr", 1, 0);

        // clamp: 7 requested, only 4 slots exist
        do_start("clamp", 3'd7);
        stream("clamp", 16, 32'h200, 1, 1'b0);
        cfg_valid_i = 1'b1;
        cfg_data_i  = 32'h5555_5555;
        chk_finish("clamp");
        cfg_valid_i = 1'b0;
        chk_arr("clamp_arr", 0, 32'h200);

        // back-pressure: random valid gaps
        do_start("bp", 3'd3);
        stream("bp", 16, 32'h100, 1, 1'b1);
        chk_finish("bp");
        chk_arr("bp_arr", 0, 32'h100);

        // abort concurrent with beat 5; start ignored mid-load
        do_start("abort", 3'd3);
        start_i = 1'b1;
        stream("abort", 4, 32'h300, 1, 1'b0);
        start_i     = 1'b0;
        cfg_valid_i = 1'b1;
        cfg_data_i  = 32'h304;
        abort_i     = 1'b1;
        tick();
        abort_i     = 1'b0;
        cfg_valid_i = 1'b0;
        chk("abort_busy",  32'(busy_o),      32'd0);
        chk("abort_ready", 32'(cfg_ready_o), 32'd0);
        chk("abort_done",  32'(done_o),      32'd0);
        chk_arr("abort_arr", 2, 0);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        do_start("reload", 3'd3);
        stream("reload", 16, 32'h400, 1, 1'b0);
        chk_finish("reload");
        chk_arr("reload_arr", 0, 32'h400);

        // reset in the middle of a load
        do_start("rstmid", 3'd3);
        stream("rstmid", 3, 32'h500, 1, 1'b0);
        rst_n_i = 1'b0;
        tick();
        chk("rstmid_busy",  32'(busy_o),      32'd0);
        chk("rstmid_ready", 32'(cfg_ready_o), 32'd0);
        chk_arr("rstmid_arr", 3, 0);
        rst_n_i = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cfg_loader_pea.md
# cfg_loader_pea

Write-side counterpart of the PEA configuration path. Accepts PE configuration words streamed by the external system over a valid/ready channel, in the order [PEA_ROW[TIME[PEA_COL]]]. Writes each word into the per-PE, per-time-slot configuration storage, whose full array is exposed as `reg_cfg_pea_o` and feeds the PEA configuration-read path. Sits between the system-side config port and the PEA control logic.

## Interface
Parameters (from `pea_pkg`, not overridable):
- `N`, package value: PEA rows.
- `M`, package value: PEA columns.
- `KMEM_SIZE`, package value: time slots per PE.
- `N_CFG_BITS_PE`, package value: config word width.
- `N_CFG_ADDR_BITS`, package value: time-slot index width.

Ports:
- `clk_i` in 1: clock.
- `rst_n_i` in 1: reset, synchronous, active-low.
- `start_i` in 1: begin a load; sampled only in IDLE.
- `last_step_i` in `N_CFG_ADDR_BITS`: last time slot to load; sampled with `start_i`.
- `abort_i` in 1: terminate the load in progress.
- `cfg_valid_i` in 1: config word valid.
- `cfg_data_i` in `N_CFG_BITS_PE`: config word.
- `cfg_ready_o` out 1: loader accepts a word.
- `reg_cfg_pea_o` out `[N][M][KMEM_SIZE][N_CFG_BITS_PE]`: configuration storage.
- `busy_o` out 1: load in progress.
- `done_o` out 1: one-cycle pulse when the last word is written.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - `start_i`=1 → LOAD next cycle.
  - Clear counters col=0, step=0, row=0.
  - Latch `last_step_q` = min(`last_step_i`, KMEM_SIZE-1).
- LOAD:
  - `cfg_ready_o`=1.
  - On handshake (`cfg_valid_i`&&`cfg_ready_o`), write `reg_cfg_pea_o[row][col][step]` = `cfg_data_i`.
  - Counter advance per beat: col++. At col=M-1: col=0, step++. At step=`last_step_q`: step=0, row++.
  - Beat at (N-1, `last_step_q`, M-1) → DONE.
- DONE: `done_o`=1 for exactly one cycle, then IDLE.
- Total beats per load = N·M·(`last_step_q`+1).
- Slots above `last_step_q` are never written and keep their prior contents.
- `abort_i` in LOAD:
  - Return to IDLE next cycle with no `done_o`.
  - Words already written stay written.
  - A handshake in the same cycle as `abort_i` is still written.
- `start_i` in LOAD or DONE is ignored.
- `abort_i` outside LOAD is ignored.
- `cfg_valid_i` outside LOAD: no write, no counter change; `cfg_ready_o`=0.
- Storage holds its value outside writes. It is never cleared except by reset.

## Timing
- Reset values:
  - State=IDLE; counters=0.
  - `reg_cfg_pea_o`=0; `cfg_ready_o`=0; `busy_o`=0; `done_o`=0.
- Reset asserted mid-load returns all of the above to reset values on the next edge.
- `cfg_ready_o` and `busy_o` are registered (decoded from state): `busy_o`=1 in LOAD and DONE.
- `start_i` at edge t → `cfg_ready_o`=1 from cycle t+1.
- Word accepted at edge t is visible on `reg_cfg_pea_o` after edge t (1-cycle write latency).
- Last beat at edge t:
  - Cycle t+1: `done_o`=1, `cfg_ready_o`=0.
  - Cycle t+2: IDLE, so a new `start_i` takes effect from t+2.
- Sustained throughput: one word per cycle; no bubbles across col/step/row wraps.
- `cfg_valid_i` may toggle freely. The counters advance only on handshake.

## Structure
- `pea_pkg` additions:
  - `cfg_ldr_state_t` enum {IDLE, LOAD, DONE}.
  - `N_ROW_BITS` = $clog2(N); `N_COL_BITS` = $clog2(M), each minimum 1.
- Reuse the existing `N_CFG_ADDR_BITS` for the step counter.
- One sub-module: `cfg_idx_cnt`, the nested col/step/row counter.
  - Inputs: `en`, `clr`, `last_step`.
  - Outputs: indices and `last_beat`.
- FSM and storage array live in the top module.

## Test plan
Bench values: N=2, M=2, KMEM_SIZE=4, N_CFG_BITS_PE=32.
- Full load: `start_i` with `last_step_i`=3, stream 16 words 0x100..0x10F back-to-back.
  - `reg_cfg_pea_o[r][c][s]` = 0x100 + r·8 + s·2 + c.
  - `done_o` pulses once, in the cycle after word 16.
- Partial load: preload all slots with 0xFFFF_FFFF, then load with `last_step_i`=1 and 8 words 0xA0..0xA7.
  - Slots 0–1 hold the new words; slots 2–3 still read 0xFFFF_FFFF.
- Clamp: `last_step_i`=7 → exactly 16 beats accepted; `cfg_ready_o`=0 after the 16th.
- Backpressure: random `cfg_valid_i` gaps (~50% duty) give the same final array as the full-load case; no skipped or duplicated index.
- Abort: `abort_i` concurrent with beat 5.
  - Beats 1–5 written; no `done_o`; IDLE next cycle.
  - A following `start_i` reloads from (0,0,0).
- Reset mid-load: `rst_n_i`=0 after beat 3 → array all zeros, `busy_o`=0, `cfg_ready_o`=0 on the next edge.
